// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: operation codes, FSM states,
// byte-mask constants and small decode helpers used by the FSM and the
// lane formatter.
package lsu_pkg;

    localparam int LSU_XLEN     = 32;
    localparam int LSU_RD_W     = 4;
    localparam int LSU_OP_WIDTH = 4;

    // Operation codes carried on i_lsu_op
    localparam logic [LSU_OP_WIDTH-1:0] LSU_NONE = 4'd0;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LB   = 4'd1;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LH   = 4'd2;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LW   = 4'd3;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LBU  = 4'd4;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_LHU  = 4'd5;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SB   = 4'd6;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SH   = 4'd7;
    localparam logic [LSU_OP_WIDTH-1:0] LSU_SW   = 4'd8;

    // Byte-enable patterns
    localparam logic [3:0] MASK_NONE    = 4'b0000;
    localparam logic [3:0] MASK_BYTE0   = 4'b0001;
    localparam logic [3:0] MASK_HALF_LO = 4'b0011;
    localparam logic [3:0] MASK_HALF_HI = 4'b1100;
    localparam logic [3:0] MASK_WORD    = 4'b1111;

    // LSU transaction states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    function automatic logic op_is_load(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_LB) || (op == LSU_LH) || (op == LSU_LW) ||
               (op == LSU_LBU) || (op == LSU_LHU);
    endfunction

    function automatic logic op_is_store(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic logic op_is_half(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_LH) || (op == LSU_LHU) || (op == LSU_SH);
    endfunction

    function automatic logic op_is_word(input logic [LSU_OP_WIDTH-1:0] op);
        return (op == LSU_LW) || (op == LSU_SW);
    endfunction

endpackage

// File: rtl/lsu_fmt.sv
// Combinational lane formatter: store data replication and byte enables,
// load lane extraction with sign/zero extension, and misalignment detection.
module lsu_fmt
    import lsu_pkg::*;
(
    input  logic [LSU_OP_WIDTH-1:0] req_op,
    input  logic [1:0]              req_off,
    input  logic [LSU_XLEN-1:0]     req_rs2,
    input  logic [LSU_OP_WIDTH-1:0] rsp_op,
    input  logic [1:0]              rsp_off,
    input  logic [LSU_XLEN-1:0]     rsp_rdata,
    output logic                    req_is_mem,
    output logic                    req_is_store,
    output logic                    req_misalign,
    output logic [LSU_XLEN-1:0]     req_wdata,
    output logic [3:0]              req_wmask,
    output logic                    rsp_is_load,
    output logic [LSU_XLEN-1:0]     rsp_load_data
);

    logic [LSU_XLEN-1:0] byte_rep;
    logic [LSU_XLEN-1:0] half_rep;
    logic [7:0]          byte_sel;
    logic [15:0]         half_sel;

    // Memory expects the data already sitting in the addressed lane; copying
    // it into every lane lets the byte enables alone pick the target.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign byte_rep[gi*8 +: 8] = req_rs2[7:0];
            assign half_rep[gi*8 +: 8] = req_rs2[(gi % 2)*8 +: 8];
        end
    endgenerate

    // Request-side decode: memory/store classification and misalignment
    always_comb begin
        req_is_mem   = op_is_load(req_op) || op_is_store(req_op);
        req_is_store = op_is_store(req_op);
        req_misalign = (op_is_half(req_op) && req_off[0]) ||
                       (op_is_word(req_op) && (req_off != 2'b00));
    end

    // Store data and byte-enable generation (loads leave both at zero)
    always_comb begin
        req_wdata = '0;
        req_wmask = MASK_NONE;
        case (req_op)
            LSU_SB: begin
                req_wdata = byte_rep;
                req_wmask = MASK_BYTE0 << req_off;
            end
            LSU_SH: begin
                req_wdata = half_rep;
                req_wmask = req_off[1] ? MASK_HALF_HI : MASK_HALF_LO;
            end
            LSU_SW: begin
                req_wdata = req_rs2;
                req_wmask = MASK_WORD;
            end
            default: ;
        endcase
    end

    // Load lane selection using the offset captured with the request
    always_comb begin
        case (rsp_off)
            2'd0:    byte_sel = rsp_rdata[7:0];
            2'd1:    byte_sel = rsp_rdata[15:8];
            2'd2:    byte_sel = rsp_rdata[23:16];
            default: byte_sel = rsp_rdata[31:24];
        endcase
        half_sel    = rsp_off[1] ? rsp_rdata[31:16] : rsp_rdata[15:0];
        rsp_is_load = op_is_load(rsp_op);
    end

    // Sign or zero extension of the selected lane
    always_comb begin
        rsp_load_data = '0;
        case (rsp_op)
            LSU_LB:  rsp_load_data = {{24{byte_sel[7]}}, byte_sel};
            LSU_LBU: rsp_load_data = {24'd0, byte_sel};
            LSU_LH:  rsp_load_data = {{16{half_sel[15]}}, half_sel};
            LSU_LHU: rsp_load_data = {16'd0, half_sel};
            LSU_LW:  rsp_load_data = rsp_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store stage: accepts one EXU packet at a time, performs at most one
// data-memory transaction (req/gnt then rvalid) and hands a registered
// writeback packet to the WBU over valid/ready.
module lsu
    import lsu_pkg::*;
#(
    parameter int CPU_WIDTH    = LSU_XLEN,
    parameter int RD_IDX_WIDTH = LSU_RD_W
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [LSU_OP_WIDTH-1:0] i_lsu_op,
    input  logic [CPU_WIDTH-1:0]    i_exu_rd_data,
    input  logic [CPU_WIDTH-1:0]    i_rs2_data,
    input  logic [RD_IDX_WIDTH-1:0] i_rd_idx,
    output logic                    o_mem_req,
    output logic                    o_mem_we,
    output logic [CPU_WIDTH-1:0]    o_mem_addr,
    output logic [CPU_WIDTH-1:0]    o_mem_wdata,
    output logic [3:0]              o_mem_wmask,
    input  logic                    i_mem_gnt,
    input  logic                    i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0]    i_mem_rdata,
    output logic                    o_valid,
    input  logic                    i_wbu_ready,
    output logic [CPU_WIDTH-1:0]    o_wb_data,
    output logic [RD_IDX_WIDTH-1:0] o_wb_rd_idx,
    output logic                    o_wb_wen,
    output logic                    o_misalign
);

    lsu_state_e state_q, state_d;

    logic                    mem_req_q,   mem_req_d;
    logic                    mem_we_q,    mem_we_d;
    logic [CPU_WIDTH-1:0]    mem_addr_q,  mem_addr_d;
    logic [CPU_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
    logic [3:0]              mem_wmask_q, mem_wmask_d;
    logic [LSU_OP_WIDTH-1:0] op_q,        op_d;
    logic [1:0]              off_q,       off_d;
    logic [RD_IDX_WIDTH-1:0] rd_idx_q,    rd_idx_d;
    logic                    valid_q,     valid_d;
    logic [CPU_WIDTH-1:0]    wb_data_q,   wb_data_d;
    logic                    wb_wen_q,    wb_wen_d;
    logic                    misalign_q,  misalign_d;

    logic                    ready;
    logic                    accept;
    logic                    rsp_done;
    logic                    req_is_mem;
    logic                    req_is_store;
    logic                    req_misalign;
    logic [CPU_WIDTH-1:0]    req_wdata;
    logic [3:0]              req_wmask;
    logic                    rsp_is_load;
    logic [CPU_WIDTH-1:0]    rsp_load_data;

    // Request fields come straight from the EXU; response decode uses the
    // op and byte offset captured at acceptance.
    lsu_fmt u_fmt (
        .req_op        (i_lsu_op),
        .req_off       (i_exu_rd_data[1:0]),
        .req_rs2       (i_rs2_data),
        .rsp_op        (op_q),
        .rsp_off       (off_q),
        .rsp_rdata     (i_mem_rdata),
        .req_is_mem    (req_is_mem),
        .req_is_store  (req_is_store),
        .req_misalign  (req_misalign),
        .req_wdata     (req_wdata),
        .req_wmask     (req_wmask),
        .rsp_is_load   (rsp_is_load),
        .rsp_load_data (rsp_load_data)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a grant and response in the same cycle skip WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (!req_is_mem || req_misalign) ? ST_DONE : ST_REQ;
                end
            end
            ST_REQ: begin
                if (i_mem_gnt) begin
                    state_d = i_mem_rvalid ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (i_wbu_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from state; only IDLE takes a new packet
    always_comb begin
        ready  = (state_q == ST_IDLE);
        accept = i_valid && ready;
        rsp_done = i_mem_rvalid &&
                   (((state_q == ST_REQ) && i_mem_gnt) || (state_q == ST_WAIT));
    end

    // Datapath next values for the request and writeback registers
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        op_d        = op_q;
        off_d       = off_q;
        rd_idx_d    = rd_idx_q;
        valid_d     = valid_q;
        wb_data_d   = wb_data_q;
        wb_wen_d    = wb_wen_q;
        misalign_d  = misalign_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d     = i_lsu_op;
                    off_d    = i_exu_rd_data[1:0];
                    rd_idx_d = i_rd_idx;
                    if (!req_is_mem) begin
                        valid_d   = 1'b1;
                        wb_data_d = i_exu_rd_data;
                        wb_wen_d  = (i_rd_idx != '0);
                    end else if (req_misalign) begin
                        valid_d    = 1'b1;
                        misalign_d = 1'b1;
                        wb_wen_d   = 1'b0;
                        wb_data_d  = '0;
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_is_store;
                        mem_addr_d  = {i_exu_rd_data[CPU_WIDTH-1:2], 2'b00};
                        mem_wdata_d = req_wdata;
                        mem_wmask_d = req_wmask;
                    end
                end
            end
            ST_REQ: begin
                if (i_mem_gnt) begin
                    mem_req_d = 1'b0;
                end
            end
            ST_DONE: begin
                if (i_wbu_ready) begin
                    valid_d    = 1'b0;
                    misalign_d = 1'b0;
                    wb_wen_d   = 1'b0;
                end
            end
            default: ;
        endcase

        // Stores complete with an ack only; loads write back the formatted lane
        if (rsp_done) begin
            valid_d = 1'b1;
            if (rsp_is_load) begin
                wb_data_d = rsp_load_data;
                wb_wen_d  = (rd_idx_q != '0);
            end else begin
                wb_data_d = '0;
                wb_wen_d  = 1'b0;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= MASK_NONE;
            op_q        <= LSU_NONE;
            off_q       <= 2'b00;
            rd_idx_q    <= '0;
            valid_q     <= 1'b0;
            wb_data_q   <= '0;
            wb_wen_q    <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            op_q        <= op_d;
            off_q       <= off_d;
            rd_idx_q    <= rd_idx_d;
            valid_q     <= valid_d;
            wb_data_q   <= wb_data_d;
            wb_wen_q    <= wb_wen_d;
            misalign_q  <= misalign_d;
        end
    end

    assign o_ready     = ready;
    assign o_mem_req   = mem_req_q;
    assign o_mem_we    = mem_we_q;
    assign o_mem_addr  = mem_addr_q;
    assign o_mem_wdata = mem_wdata_q;
    assign o_mem_wmask = mem_wmask_q;
    assign o_valid     = valid_q;
    assign o_wb_data   = wb_data_q;
    assign o_wb_rd_idx = rd_idx_q;
    assign o_wb_wen    = wb_wen_q;
    assign o_misalign  = misalign_q;

endmodule

// File: tb/tb_lsu.sv
// Scoreboard bench for the load/store unit: stimulus pushes expected memory
// requests and writeback packets; monitors compare them as the DUT shows them.
module tb_lsu;
    import lsu_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_lsu_op;
    logic [31:0] i_exu_rd_data;
    logic [31:0] i_rs2_data;
    logic [3:0]  i_rd_idx;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_wmask;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_valid;
    logic        i_wbu_ready;
    logic [31:0] o_wb_data;
    logic [3:0]  o_wb_rd_idx;
    logic        o_wb_wen;
    logic        o_misalign;

    lsu dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_lsu_op      (i_lsu_op),
        .i_exu_rd_data (i_exu_rd_data),
        .i_rs2_data    (i_rs2_data),
        .i_rd_idx      (i_rd_idx),
        .o_mem_req     (o_mem_req),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata),
        .o_mem_wmask   (o_mem_wmask),
        .i_mem_gnt     (i_mem_gnt),
        .i_mem_rvalid  (i_mem_rvalid),
        .i_mem_rdata   (i_mem_rdata),
        .o_valid       (o_valid),
        .i_wbu_ready   (i_wbu_ready),
        .o_wb_data     (o_wb_data),
        .o_wb_rd_idx   (o_wb_rd_idx),
        .o_wb_wen      (o_wb_wen),
        .o_misalign    (o_misalign)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] data;
        logic        wen;
        logic [3:0]  rd;
        logic        mis;
        logic        chk_data;
    } wb_exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        chk_wdata;
    } req_exp_t;

    wb_exp_t  wb_q[$];
    req_exp_t req_q[$];
    wb_exp_t  wb_e;
    req_exp_t req_e;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event not seen or unexpected", name);
    endfunction

    // Writeback monitor: every cycle o_valid is up the packet must match the
    // queue head, which makes held values under backpressure checked too.
    always @(negedge i_clk) begin
        if (i_rst && o_valid) begin
            chk("ready_low_while_valid", {31'd0, o_ready}, 32'd0);
            if (wb_q.size() == 0) begin
                fail_now("unexpected_wb");
            end else begin
                wb_e = wb_q[0];
                if (wb_e.chk_data) chk("wb_data", o_wb_data, wb_e.data);
                chk("wb_wen", {31'd0, o_wb_wen}, {31'd0, wb_e.wen});
                chk("wb_rd", {28'd0, o_wb_rd_idx}, {28'd0, wb_e.rd});
                chk("wb_misalign", {31'd0, o_misalign}, {31'd0, wb_e.mis});
                if (i_wbu_ready) begin
                    void'(wb_q.pop_front());
                    $display("wb   data=0x%08h rd=%0d wen=%0b mis=%0b", o_wb_data, o_wb_rd_idx, o_wb_wen, o_misalign);
                end
            end
        end
    end

    // Memory request monitor: fields must match and stay put until granted
    always @(negedge i_clk) begin
        if (i_rst && o_mem_req) begin
            if (req_q.size() == 0) begin
                fail_now("unexpected_mem_req");
            end else begin
                req_e = req_q[0];
                chk("mem_addr", o_mem_addr, req_e.addr);
                chk("mem_we", {31'd0, o_mem_we}, {31'd0, req_e.we});
                chk("mem_wmask", {28'd0, o_mem_wmask}, {28'd0, req_e.wmask});
                if (req_e.chk_wdata) chk("mem_wdata", o_mem_wdata, req_e.wdata);
                if (i_mem_gnt) begin
                    void'(req_q.pop_front());
                    $display("mem  addr=0x%08h we=%0b wdata=0x%08h wmask=%04b", o_mem_addr, o_mem_we, o_mem_wdata, o_mem_wmask);
                end
            end
        end
    end

    task automatic push_wb(input logic [31:0] d, input logic wen, input logic [3:0] rd,
                           input logic mis, input logic cd);
        wb_exp_t e;
        e.data = d; e.wen = wen; e.rd = rd; e.mis = mis; e.chk_data = cd;
        wb_q.push_back(e);
    endtask

    task automatic push_req(input logic [31:0] a, input logic we, input logic [31:0] wd,
                            input logic [3:0] wm, input logic cw);
        req_exp_t e;
        e.addr = a; e.we = we; e.wdata = wd; e.wmask = wm; e.chk_wdata = cw;
        req_q.push_back(e);
    endtask

    // Present one packet; returns one cycle after the accepting edge
    task automatic issue(input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] rd);
        int guard = 0;
        while (!o_ready && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        if (!o_ready) fail_now("issue_timeout");
        i_valid = 1'b1; i_lsu_op = op; i_exu_rd_data = a; i_rs2_data = d; i_rd_idx = rd;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
    endtask

    // Act as memory: grant after gnt_dly cycles, respond rv_dly cycles later
    task automatic mem_serve(input int gnt_dly, input int rv_dly, input logic [31:0] rdata);
        int guard = 0;
        while (!o_mem_req && guard < 20) begin
            @(posedge i_clk); #1;
            guard++;
        end
        if (!o_mem_req) fail_now("mem_req_timeout");
        repeat (gnt_dly) begin @(posedge i_clk); #1; end
        i_mem_gnt = 1'b1;
        i_mem_rdata = rdata;
        if (rv_dly == 0) i_mem_rvalid = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        if (rv_dly > 0) begin
            repeat (rv_dly - 1) begin @(posedge i_clk); #1; end
            i_mem_rvalid = 1'b1;
            @(posedge i_clk); #1;
            i_mem_rvalid = 1'b0;
        end
    endtask

    task automatic wait_drain(input string name);
        int guard = 0;
        while ((wb_q.size() != 0) && guard < 50) begin
            @(posedge i_clk); #1;
            guard++;
        end
        if (wb_q.size() != 0) fail_now(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        i_rst = 1'b0; i_valid = 1'b0; i_lsu_op = LSU_NONE; i_exu_rd_data = '0;
        i_rs2_data = '0; i_rd_idx = '0; i_mem_gnt = 1'b0; i_mem_rvalid = 1'b0;
        i_mem_rdata = '0; i_wbu_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("rst_wb_data", o_wb_data, 32'd0);
        chk("rst_wmask", {28'd0, o_mem_wmask}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;

        // ALU pass-through, one cycle latency, no memory traffic
        push_wb(32'h1234_5678, 1'b1, 4'd5, 1'b0, 1'b1);
        issue(LSU_NONE, 32'h1234_5678, 32'h0, 4'd5);
        chk("none_latency", {31'd0, o_valid}, 32'd1);
        wait_drain("none_drain");

        // LB sign extend: top byte 0x80 of 0x80FF0011
        push_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'hFFFF_FF80, 1'b1, 4'd6, 1'b0, 1'b1);
        issue(LSU_LB, 32'h8000_0003, 32'h0, 4'd6);
        mem_serve(2, 1, 32'h80FF_0011);
        wait_drain("lb_drain");

        // LBU of the same word
        push_req(32'h8000_0000, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'h0000_0080, 1'b1, 4'd7, 1'b0, 1'b1);
        issue(LSU_LBU, 32'h8000_0003, 32'h0, 4'd7);
        mem_serve(2, 1, 32'h80FF_0011);
        wait_drain("lbu_drain");

        // SH to upper half
        push_req(32'h8000_0100, 1'b1, 32'hBEEF_BEEF, 4'b1100, 1'b1);
        push_wb(32'h0, 1'b0, 4'd8, 1'b0, 1'b1);
        issue(LSU_SH, 32'h8000_0102, 32'hDEAD_BEEF, 4'd8);
        mem_serve(1, 2, 32'h0);
        wait_drain("sh_drain");

        // Misaligned LW: no request, misalign flagged
        push_wb(32'h0, 1'b0, 4'd9, 1'b1, 1'b0);
        issue(LSU_LW, 32'h8000_0001, 32'h0, 4'd9);
        wait_drain("mis_lw_drain");

        // Misaligned LH
        push_wb(32'h0, 1'b0, 4'd2, 1'b1, 1'b0);
        issue(LSU_LH, 32'h0000_0003, 32'h0, 4'd2);
        wait_drain("mis_lh_drain");

        // LW to x0: bus completes, no register write
        push_req(32'h0000_0010, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'hCAFE_F00D, 1'b0, 4'd0, 1'b0, 1'b1);
        issue(LSU_LW, 32'h0000_0010, 32'h0, 4'd0);
        mem_serve(0, 1, 32'hCAFE_F00D);
        wait_drain("lw_x0_drain");

        // LH upper half, response in the grant cycle
        push_req(32'h0000_0000, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'hFFFF_8001, 1'b1, 4'd4, 1'b0, 1'b1);
        issue(LSU_LH, 32'h0000_0002, 32'h0, 4'd4);
        mem_serve(0, 0, 32'h8001_7FFF);
        wait_drain("lh_drain");

        // LHU of the same
        push_req(32'h0000_0000, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'h0000_8001, 1'b1, 4'd4, 1'b0, 1'b1);
        issue(LSU_LHU, 32'h0000_0002, 32'h0, 4'd4);
        mem_serve(1, 0, 32'h8001_7FFF);
        wait_drain("lhu_drain");

        // SB to lane 1
        push_req(32'h0000_1000, 1'b1, 32'hA5A5_A5A5, 4'b0010, 1'b1);
        push_wb(32'h0, 1'b0, 4'd1, 1'b0, 1'b1);
        issue(LSU_SB, 32'h0000_1001, 32'h0000_00A5, 4'd1);
        mem_serve(0, 1, 32'h0);
        wait_drain("sb_drain");

        // SW full word
        push_req(32'h0000_0020, 1'b1, 32'h1122_3344, 4'b1111, 1'b1);
        push_wb(32'h0, 1'b0, 4'd12, 1'b0, 1'b1);
        issue(LSU_SW, 32'h0000_0020, 32'h1122_3344, 4'd12);
        mem_serve(1, 1, 32'h0);
        wait_drain("sw_drain");

        // Backpressure: LW held 3 cycles, a pending packet waits its turn
        i_wbu_ready = 1'b0;
        push_req(32'h0000_0040, 1'b0, 32'h0, 4'b0000, 1'b0);
        push_wb(32'h55AA_55AA, 1'b1, 4'd10, 1'b0, 1'b1);
        issue(LSU_LW, 32'h0000_0040, 32'h0, 4'd10);
        mem_serve(1, 1, 32'h55AA_55AA);
        guard = 0;
        while (!o_valid && guard < 20) begin @(posedge i_clk); #1; guard++; end
        if (!o_valid) fail_now("bp_valid_timeout");
        i_valid = 1'b1; i_lsu_op = LSU_NONE; i_exu_rd_data = 32'hABCD_0000; i_rd_idx = 4'd3;
        repeat (3) begin @(posedge i_clk); #1; end
        chk("bp_ready_low", {31'd0, o_ready}, 32'd0);
        chk("bp_data_held", o_wb_data, 32'h55AA_55AA);
        push_wb(32'hABCD_0000, 1'b1, 4'd3, 1'b0, 1'b1);
        i_wbu_ready = 1'b1;
        @(posedge i_clk); #1;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        wait_drain("bp_drain");

        // Asynchronous reset while waiting for a load response
        push_req(32'h0000_0080, 1'b0, 32'h0, 4'b0000, 1'b0);
        issue(LSU_LW, 32'h0000_0080, 32'h0, 4'd11);
        i_mem_gnt = 1'b1;
        @(posedge i_clk); #1;
        i_mem_gnt = 1'b0;
        #2;
        i_rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, o_valid}, 32'd0);
        chk("arst_mem_req", {31'd0, o_mem_req}, 32'd0);
        chk("arst_mem_addr", o_mem_addr, 32'd0);
        chk("arst_wb_rd", {28'd0, o_wb_rd_idx}, 32'd0);
        chk("arst_wb_wen", {31'd0, o_wb_wen}, 32'd0);
        chk("arst_ready", {31'd0, o_ready}, 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_DEAD;
        @(posedge i_clk); #1;
        i_mem_rvalid = 1'b0;
        repeat (3) begin
            @(posedge i_clk); #1;
            chk("stray_rvalid_no_valid", {31'd0, o_valid}, 32'd0);
        end

        chk("wb_queue_empty", wb_q.size(), 32'd0);
        chk("req_queue_empty", req_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
